// File: rtl/bnn_pkg.sv
// Shared types and sizes for the binarized-network inference sequencer.
package bnn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 5;
  localparam int IMG_ROWS    = 8;
  localparam int IDX_W       = 4;

  typedef logic [SCORE_W-1:0]                 score_t;
  typedef score_t [NUM_CLASSES-1:0]           scores_t;
  typedef logic [IMG_ROWS-1:0][7:0]           image_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ARGMAX  = 2'd2,
    ST_DISPLAY = 2'd3
  } seq_state_t;

endpackage

// File: rtl/bnn_inference_sequencer_argmax_serial.sv
// Serial argmax: one class per step, strict-greater update so ties keep the lowest index.
module argmax_serial #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 5,
  parameter int IDX_W       = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic                                step,
  input  logic [NUM_CLASSES-1:0][SCORE_W-1:0] scores,
  output logic                                done,
  output logic [IDX_W-1:0]                    best_idx,
  output logic [SCORE_W-1:0]                  best_score
);
  import bnn_pkg::*;

  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   best_idx_r;
  logic [SCORE_W-1:0] best_score_r;
  logic [SCORE_W-1:0] cur_score_s;
  logic [IDX_W-1:0]   nxt_idx_s;
  logic [SCORE_W-1:0] nxt_score_s;
  logic               last_s;

  assign cur_score_s = scores[idx_r];
  assign last_s      = (idx_r == IDX_W'(NUM_CLASSES - 1));
  assign done        = step && last_s;
  // Exposed as the post-step value so the caller can commit on the final step edge.
  assign best_idx    = nxt_idx_s;
  assign best_score  = nxt_score_s;

  // Best-so-far including the class currently under the index; class 0 seeds it.
  always_comb begin
    nxt_idx_s   = best_idx_r;
    nxt_score_s = best_score_r;
    if ((idx_r == {IDX_W{1'b0}}) || (cur_score_s > best_score_r)) begin
      nxt_idx_s   = idx_r;
      nxt_score_s = cur_score_s;
    end else begin
      nxt_idx_s   = best_idx_r;
      nxt_score_s = best_score_r;
    end
  end

  // Index counter and best registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r        <= {IDX_W{1'b0}};
      best_idx_r   <= {IDX_W{1'b0}};
      best_score_r <= {SCORE_W{1'b0}};
    end else if (load) begin
      idx_r        <= {IDX_W{1'b0}};
      best_idx_r   <= {IDX_W{1'b0}};
      best_score_r <= {SCORE_W{1'b0}};
    end else if (step) begin
      idx_r        <= last_s ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      best_idx_r   <= nxt_idx_s;
      best_score_r <= nxt_score_s;
    end else begin
      idx_r        <= idx_r;
      best_idx_r   <= best_idx_r;
      best_score_r <= best_score_r;
    end
  end

endmodule

// File: rtl/bnn_inference_sequencer.sv
// Inference sequencer: image register, settle timer, serial argmax and LCD handshake
// with a capture trigger spanning exactly the settle window.
module bnn_inference_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_CLASSES   = 10,
  parameter int SCORE_W       = 5
) (
  input  logic                                usb_clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [2:0]                          wr_addr,
  input  logic [7:0]                          wr_data,
  input  logic                                start,
  input  logic [NUM_CLASSES-1:0][SCORE_W-1:0] bnn_scores_i,
  input  logic                                lcd_done,
  output logic [7:0][7:0]                     image_o,
  output logic                                busy,
  output logic                                trig,
  output logic                                result_valid,
  output logic [3:0]                          result_class,
  output logic [SCORE_W-1:0]                  result_score,
  output logic                                lcd_start
);
  import bnn_pkg::*;

  seq_state_t                          state_r, next_state_s;
  image_t                              image_r;
  logic [7:0]                          cnt_r;
  logic [NUM_CLASSES-1:0][SCORE_W-1:0] scores_r;
  logic                                busy_r, trig_r, valid_r, lcd_start_r;
  logic [3:0]                          class_r;
  logic [SCORE_W-1:0]                  score_r;
  logic                                accept_s, capture_s, finish_s, release_s, wr_s;
  logic                                am_done_s;
  logic [3:0]                          am_idx_s;
  logic [SCORE_W-1:0]                  am_score_s;

  assign wr_s = (state_r == ST_IDLE) && wr_en;

  // State register.
  always_ff @(posedge usb_clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and single-cycle control strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    finish_s     = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          next_state_s = ST_SETTLE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == 8'd1) begin
          capture_s    = 1'b1;
          next_state_s = ST_ARGMAX;
        end else begin
          next_state_s = ST_SETTLE;
        end
      end
      ST_ARGMAX: begin
        if (am_done_s) begin
          finish_s     = 1'b1;
          next_state_s = ST_DISPLAY;
        end else begin
          next_state_s = ST_ARGMAX;
        end
      end
      ST_DISPLAY: begin
        if (lcd_done) begin
          release_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DISPLAY;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Image rows, settle counter and score snapshot.
  always_ff @(posedge usb_clk or negedge rst) begin
    if (!rst) begin
      image_r  <= {(IMG_ROWS*8){1'b0}};
      cnt_r    <= 8'd0;
      scores_r <= {(NUM_CLASSES*SCORE_W){1'b0}};
    end else begin
      if (wr_s) begin
        image_r[wr_addr] <= wr_data;
      end else begin
        image_r <= image_r;
      end
      if (accept_s) begin
        cnt_r <= 8'(SETTLE_CYCLES);
      end else if ((state_r == ST_SETTLE) && !capture_s) begin
        cnt_r <= cnt_r - 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (capture_s) begin
        scores_r <= bnn_scores_i;
      end else begin
        scores_r <= scores_r;
      end
    end
  end

  // Status flags and the committed result.
  always_ff @(posedge usb_clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= 1'b0;
      trig_r      <= 1'b0;
      valid_r     <= 1'b0;
      lcd_start_r <= 1'b0;
      class_r     <= 4'd0;
      score_r     <= {SCORE_W{1'b0}};
    end else begin
      lcd_start_r <= finish_s;
      if (accept_s) begin
        busy_r  <= 1'b1;
        trig_r  <= 1'b1;
        valid_r <= 1'b0;
      end else if (capture_s) begin
        trig_r  <= 1'b0;
      end else if (finish_s) begin
        valid_r <= 1'b1;
        class_r <= am_idx_s;
        score_r <= am_score_s;
      end else if (release_s) begin
        busy_r  <= 1'b0;
      end else begin
        busy_r  <= busy_r;
      end
    end
  end

  argmax_serial #(
    .NUM_CLASSES (NUM_CLASSES),
    .SCORE_W     (SCORE_W),
    .IDX_W       (4)
  ) u_argmax (
    .clk        (usb_clk),
    .rst        (rst),
    .load       (capture_s),
    .step       (state_r == ST_ARGMAX),
    .scores     (scores_r),
    .done       (am_done_s),
    .best_idx   (am_idx_s),
    .best_score (am_score_s)
  );

  assign image_o      = image_r;
  assign busy         = busy_r;
  assign trig         = trig_r;
  assign result_valid = valid_r;
  assign result_class = class_r;
  assign result_score = score_r;
  assign lcd_start    = lcd_start_r;

endmodule
